// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; the master is the pipeline plus memory.
interface load_store_unit_if #(
  parameter int unsigned WIDX_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [WIDX_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: byte-lane extraction with sign/zero extension on loads,
// read-modify-write for sub-word stores so memory only sees full-word writes.
module load_store_unit #(
  parameter int unsigned WIDX_W = 6
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [WIDX_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic [1:0]         off;
  logic               req_err;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_ext;
  logic [31:0]        merged;

  assign off            = addr_q[1:0];
  assign bus.mem_addr   = addr_q[WIDX_W+1:2];
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // Unsigned variants are load-only; everything above 010 is illegal for stores.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{off, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{off[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (funct3_q[0]) merged[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merged[{off, 3'b000} +: 8]     = wdata_q[7:0];
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_wdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[WIDX_W+1:0];
          wdata_d  = bus.req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            state_d     = WRITE;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d     = WRITE;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_rdata_d = ld_ext;
          resp_err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_we_d     = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// compared against an arithmetic model of memory and load/store semantics.
module tb_load_store_unit;
  localparam int unsigned WIDX_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.WIDX_W(WIDX_W)) bus();
  load_store_unit #(.WIDX_W(WIDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Data memory: combinational read, full-word write; pl_* is a bench-side preload port.
  logic [31:0]       mem [DEPTH];
  logic              pl_en;
  logic [WIDX_W-1:0] pl_idx;
  logic [31:0]       pl_val;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  logic [31:0] ref_mem [DEPTH];
  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned f = f3;
    int unsigned off = addr % 4;
    int unsigned size = 1 << (f % 4);
    logic legal;
    if (we) legal = (f <= 2);
    else    legal = (f <= 2) || (f == 4) || (f == 5);
    return !legal || (off % size != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3,
                                         input int unsigned off);
    longint unsigned v;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFFFF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (off / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF0000;
      end
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input logic [2:0] f3,
                                          input int unsigned off, input logic [31:0] wdata);
    logic [31:0] mask;
    int unsigned sh;
    if (f3 == 3'd2) return wdata;
    if (f3 == 3'd0) begin sh = 8 * off;        mask = 32'h000000FF << sh; end
    else            begin sh = 16 * (off / 2); mask = 32'h0000FFFF << sh; end
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

  function automatic int m_lat(input logic we, input logic [2:0] f3, input logic err);
    if (err) return 1;
    if (!we || f3 == 3'd2) return 2;
    return 3;
  endfunction

  // ---------------- drivers ----------------
  task automatic preload(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx[WIDX_W-1:0];
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // One request; reports latency after acceptance (-1 on timeout) and mem_we cycles seen.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int we_cycles, output logic ready0);
    @(negedge clk);
    ready0         = bus.req_ready;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = -1; we_cycles = 0; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_we) we_cycles++;
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else pass_cnt++;
    total_cnt++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); else pass_cnt++;
    total_cnt++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.resp_err); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else pass_cnt++;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [5] = '{32'h11, 32'h10, 32'h10, 32'h10, 32'h10};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] exps  [5] = '{32'hFFFFFFFF, 32'h0000003C, 32'hFFFFFF3C, 32'h0000FF3C, 32'h0000FF3C};
    int lat, wc; logic [31:0] rd; logic er, rdy;
    preload(4, 32'h0000FF3C);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], addrs[i], $urandom, lat, rd, er, wc, rdy);
      total_cnt++; if (rdy !== 1'b1) $display("FAIL load%0d_ready: got %b want 1", i, rdy); else pass_cnt++;
      total_cnt++; if (rd !== exps[i]) $display("FAIL load%0d_rdata: got %h want %h", i, rd, exps[i]); else pass_cnt++;
      total_cnt++; if (lat !== 2) $display("FAIL load%0d_latency: got %0d want 2", i, lat); else pass_cnt++;
      total_cnt++; if (er !== 1'b0 || wc !== 0) $display("FAIL load%0d_err_we: got err=%b we_cycles=%0d want 0/0", i, er, wc); else pass_cnt++;
    end
  endtask

  task automatic test_rmw();
    int lat, wc; logic [31:0] rd; logic er, rdy;
    preload(8, 32'h12345678);
    do_req(1'b1, 3'b000, 32'h22, 32'hFFFFFFAB, lat, rd, er, wc, rdy);
    total_cnt++; if (lat !== 3) $display("FAIL sb_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (wc !== 1) $display("FAIL sb_we_cycles: got %0d want 1", wc); else pass_cnt++;
    total_cnt++; if (mem[8] !== 32'h12AB5678) $display("FAIL sb_word: got %h want 12ab5678", mem[8]); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sb_resp: got rdata=%h err=%b want 0/0", rd, er); else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h20, 32'h0000BEEF, lat, rd, er, wc, rdy);
    total_cnt++; if (lat !== 3 || wc !== 1) $display("FAIL sh_timing: got lat=%0d we=%0d want 3/1", lat, wc); else pass_cnt++;
    total_cnt++; if (mem[8] !== 32'h12ABBEEF) $display("FAIL sh_word: got %h want 12abbeef", mem[8]); else pass_cnt++;
    ref_mem[8] = 32'h12ABBEEF;
  endtask

  task automatic test_sw_lw();
    int lat, wc; logic [31:0] rd; logic er, rdy;
    do_req(1'b1, 3'b010, 32'h24, 32'hDEADBEEF, lat, rd, er, wc, rdy);
    total_cnt++; if (lat !== 2 || wc !== 1) $display("FAIL sw_timing: got lat=%0d we=%0d want 2/1", lat, wc); else pass_cnt++;
    total_cnt++; if (mem[9] !== 32'hDEADBEEF) $display("FAIL sw_word: got %h want deadbeef", mem[9]); else pass_cnt++;
    ref_mem[9] = 32'hDEADBEEF;
    do_req(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er, wc, rdy);
    total_cnt++; if (rdy !== 1'b1) $display("FAIL lw_after_sw_ready: got %b want 1", rdy); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL lw_after_sw_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_after_sw_rdata: got %h want deadbeef", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] addrs [4] = '{32'h21, 32'h13, 32'h22, 32'h20};
    int lat, wc; logic [31:0] rd; logic er, rdy;
    for (int i = 0; i < 4; i++) begin
      do_req(wes[i], f3s[i], addrs[i], 32'hA5A5A5A5, lat, rd, er, wc, rdy);
      total_cnt++; if (er !== 1'b1) $display("FAIL err%0d_flag: got %b want 1", i, er); else pass_cnt++;
      total_cnt++; if (rd !== 32'h0) $display("FAIL err%0d_rdata: got %h want 0", i, rd); else pass_cnt++;
      total_cnt++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d want 1", i, lat); else pass_cnt++;
      total_cnt++; if (wc !== 0) $display("FAIL err%0d_mem_we: got %0d cycles want 0", i, wc); else pass_cnt++;
    end
    total_cnt++; if (mem[8] !== ref_mem[8]) $display("FAIL err_word_unchanged: got %h want %h", mem[8], ref_mem[8]); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int lat, wc, exp_lat, exp_wc, bad;
    int unsigned idx, off;
    logic [31:0] rd, addr, wdata, exp_rd;
    logic er, rdy, we, exp_err;
    logic [2:0] f3;
    for (int n = 0; n < 300; n++) begin
      we    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        f3 = legal_f3[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) != 0) addr = addr - (addr % (1 << (f3 % 4)));
      end else begin
        f3 = 3'($urandom);
      end
      idx     = (addr / 4) % DEPTH;
      off     = addr % 4;
      exp_err = m_err(we, f3, addr);
      exp_lat = m_lat(we, f3, exp_err);
      exp_wc  = (!exp_err && we) ? 1 : 0;
      exp_rd  = (exp_err || we) ? 32'h0 : m_load(ref_mem[idx], f3, off);
      if (!exp_err && we) ref_mem[idx] = m_store(ref_mem[idx], f3, off, wdata);
      do_req(we, f3, addr, wdata, lat, rd, er, wc, rdy);
      total_cnt++; if (rdy !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", n, rdy); else pass_cnt++;
      total_cnt++; if (er !== exp_err) $display("FAIL rnd%0d_err: got %b want %b (we=%b f3=%0d a=%h)", n, er, exp_err, we, f3, addr); else pass_cnt++;
      total_cnt++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, exp_lat); else pass_cnt++;
      total_cnt++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata: got %h want %h (f3=%0d a=%h)", n, rd, exp_rd, f3, addr); else pass_cnt++;
      total_cnt++; if (wc !== exp_wc) $display("FAIL rnd%0d_we_cycles: got %0d want %0d", n, wc, exp_wc); else pass_cnt++;
      total_cnt++; if (mem[idx] !== ref_mem[idx]) $display("FAIL rnd%0d_word: got %h want %h", n, mem[idx], ref_mem[idx]); else pass_cnt++;
    end
    bad = 0;
    for (int unsigned i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    total_cnt++; if (bad != 0) $display("FAIL rnd_memory_image: got %0d differing words want 0", bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h30, 32'h35, 32'h3A};
    logic [2:0]  f3s   [3] = '{3'b010, 3'b000, 3'b101};
    logic [31:0] exps  [3];
    int n_acc, n_resp, extra;
    logic acc;
    preload(12, $urandom);
    preload(13, $urandom);
    preload(14, $urandom);
    for (int i = 0; i < 3; i++) exps[i] = m_load(ref_mem[(addrs[i] / 4) % DEPTH], f3s[i], addrs[i] % 4);
    n_acc = 0; n_resp = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = f3s[0]; bus.req_addr = addrs[0];
    for (int cyc = 0; cyc < 40 && !(n_resp == 3 && n_acc == 3); cyc++) begin
      acc = bus.req_valid && bus.req_ready;
      if (bus.resp_valid) begin
        if (n_resp < 3) begin
          total_cnt++;
          if (bus.resp_rdata !== exps[n_resp] || bus.resp_err !== 1'b0)
            $display("FAIL b2b_resp%0d: got %h err=%b want %h err=0", n_resp, bus.resp_rdata, bus.resp_err, exps[n_resp]);
          else pass_cnt++;
        end
        n_resp++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc < 3) begin bus.req_funct3 = f3s[n_acc]; bus.req_addr = addrs[n_acc]; end
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
      if (acc) begin
        total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_ready_drop%0d: got %b want 0", n_acc, bus.req_ready); else pass_cnt++;
      end
    end
    bus.req_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid) extra++;
      @(negedge clk);
    end
    total_cnt++; if (n_acc !== 3) $display("FAIL b2b_accepts: got %0d want 3", n_acc); else pass_cnt++;
    total_cnt++; if (n_resp + extra !== 3) $display("FAIL b2b_resp_count: got %0d want 3", n_resp + extra); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    int seen;
    preload(8, 32'h12345678);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h000000AB;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.mem_we !== 1'b1) $display("FAIL rstw_in_write: got mem_we=%b want 1", bus.mem_we); else pass_cnt++;
    #1 rst = 1'b0;
    #1;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL rstw_we_drop: got %b want 0", bus.mem_we); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rstw_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rstw_no_resp: got %0d pulses want 0", seen); else pass_cnt++;
    total_cnt++; if (mem[8] !== 32'h12345678) $display("FAIL rstw_word: got %h want 12345678", mem[8]); else pass_cnt++;
  endtask

  initial begin
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    for (int unsigned i = 0; i < DEPTH; i++) preload(i, $urandom);
    @(negedge clk);
    rst = 1'b1;
    test_loads();
    test_rmw();
    test_sw_lw();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
